multicycle_control: RTL

- Control unit for the multicycle MIPS datapath; next generation of the single-cycle main decoder.
- Moore FSM, one instruction over 3–5+ cycles; drives IR, PC, shared memory port, register file and ALU operand muxes.
- Additions: addi and j (parameter-enabled), variable-latency memory handshake with optional timeout, illegal-opcode flag, instruction-complete strobe.

---
 rtl/mips_ctrl_pkg.sv | 63 ++++++
 rtl/mc_output_decode.sv | 81 ++++++++
 rtl/multicycle_control.sv | 138 +++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit: opcodes, FSM
// states, datapath select encodings and the registered-free control word.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXECUTE,
        ALUWB,
        BEQ,
        ADDIEX,
        ADDIWB,
        JUMP,
        ILLEGAL
    } state_t;

    // ALU operand B select
    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // ALU operation class
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Next-PC source
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Raw per-state control word, before handshake gating.
    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       illegal_op;
        logic       done;
    } ctrl_t;

endpackage

// File: rtl/mc_output_decode.sv
// Moore output table: maps the current state to its ungated control word.
module mc_output_decode
    import mips_ctrl_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    // Table lookup; every field not named for a state stays 0.
    always_comb begin
        // NOTE: assigning a full default first means no path leaves a field
        // unassigned, so no latch can be inferred.
        ctrl = '0;
        unique case (state)
            FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_src    = PCSRC_ALU;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
            end
            DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALUOP_ADD;
            end
            MEMADR, ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            MEMRD: begin
                ctrl.iord     = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.done       = 1'b1;
            end
            MEMWR: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.done      = 1'b1;
            end
            EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            ALUWB: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.done      = 1'b1;
            end
            BEQ: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_SUB;
                ctrl.pc_src    = PCSRC_ALUOUT;
                ctrl.branch    = 1'b1;
                ctrl.done      = 1'b1;
            end
            ADDIWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.done      = 1'b1;
            end
            JUMP: begin
                ctrl.pc_src   = PCSRC_JUMP;
                ctrl.pc_write = 1'b1;
                ctrl.done     = 1'b1;
            end
            ILLEGAL: begin
                ctrl.illegal_op = 1'b1;
                ctrl.done       = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: state register, next-state logic, memory wait
// counter with optional timeout, and gating of the memory-handshake strobes.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter bit ENABLE_ADDI = 1'b1,
    parameter bit ENABLE_J    = 1'b1,
    parameter int MAX_WAIT    = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       Branch,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       illegal_op,
    output logic       mem_timeout,
    output logic       instr_done
);

    localparam int WAIT_W = ($clog2(MAX_WAIT + 1) < 1) ? 1 : $clog2(MAX_WAIT + 1);

    state_t            state, state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_state;
    logic              timeout;
    logic              accept;
    ctrl_t             ctrl;

    assign wait_state = (state == FETCH) || (state == MEMRD) || (state == MEMWR);

    // Timeout fires on the limit cycle only if memory still has not answered.
    generate
        if (MAX_WAIT > 0) begin : g_timeout
            assign timeout = wait_state && !mem_ready &&
                             (wait_cnt == WAIT_W'(MAX_WAIT - 1));
        end else begin : g_no_timeout
            assign timeout = 1'b0;
        end
    endgenerate

    assign accept = mem_ready && !timeout;

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) state <= FETCH;
        else       state <= state_next;
    end

    // Wait counter: counts stalled wait-state cycles, cleared on any move.
    always_ff @(posedge clk) begin
        if (reset || timeout || (state_next != state)) wait_cnt <= '0;
        else if (wait_state && !mem_ready)             wait_cnt <= wait_cnt + 1'b1;
    end

    // Next-state selection from state, opcode and memory handshake.
    always_comb begin
        state_next = state;
        unique case (state)
            FETCH:   if (timeout) state_next = FETCH;
                     else if (mem_ready) state_next = DECODE;
            DECODE: begin
                unique case (Op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_RTYPE:     state_next = EXECUTE;
                    OP_BEQ:       state_next = BEQ;
                    OP_ADDI:      state_next = ENABLE_ADDI ? ADDIEX : ILLEGAL;
                    OP_J:         state_next = ENABLE_J ? JUMP : ILLEGAL;
                    default:      state_next = ILLEGAL;
                endcase
            end
            MEMADR:  state_next = (Op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   if (timeout) state_next = FETCH;
                     else if (mem_ready) state_next = MEMWB;
            MEMWR:   if (timeout || mem_ready) state_next = FETCH;
            EXECUTE: state_next = ALUWB;
            ADDIEX:  state_next = ADDIWB;
            default: state_next = FETCH;
        endcase
    end

    mc_output_decode u_decode (
        .state (state),
        .ctrl  (ctrl)
    );

    // Apply handshake gating to the table, then force everything low in reset.
    always_comb begin
        PCWrite     = ctrl.pc_write && ((state != FETCH) || accept);
        IRWrite     = ctrl.ir_write && accept;
        instr_done  = ctrl.done && ((state != MEMWR) || accept);
        mem_timeout = timeout;
        Branch      = ctrl.branch;
        IorD        = ctrl.iord;
        MemRead     = ctrl.mem_read;
        MemWrite    = ctrl.mem_write;
        RegDst      = ctrl.reg_dst;
        MemtoReg    = ctrl.mem_to_reg;
        RegWrite    = ctrl.reg_write;
        ALUSrcA     = ctrl.alu_src_a;
        ALUSrcB     = ctrl.alu_src_b;
        ALUOp       = ctrl.alu_op;
        PCSrc       = ctrl.pc_src;
        illegal_op  = ctrl.illegal_op;
        if (reset) begin
            PCWrite     = 1'b0;
            IRWrite     = 1'b0;
            instr_done  = 1'b0;
            mem_timeout = 1'b0;
            Branch      = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            RegDst      = 1'b0;
            MemtoReg    = 1'b0;
            RegWrite    = 1'b0;
            ALUSrcA     = 1'b0;
            ALUSrcB     = 2'b00;
            ALUOp       = 2'b00;
            PCSrc       = 2'b00;
            illegal_op  = 1'b0;
        end
    end

endmodule
